// File: rtl/datapath_arbiter_if.sv
// Bus between the sequencing requesters (master) and datapath_arbiter (slave):
// per-requester request/release/select lanes in, the muxed datapath command out.
interface datapath_arbiter_if #(
  parameter int NREQ          = 2,
  parameter int SELECTIONDECO = 3,
  parameter int SELECTIONALU  = 3
);
  // Handshake: requester i holds req[i] high to ask for the datapath. gnt (one-hot,
  // registered) names the owner. The owner ends ownership by pulsing rel[i] or by
  // dropping req[i]. rel from any requester that is not the owner has no effect.
  logic [NREQ-1:0]               req;
  logic [NREQ-1:0]               rel;
  logic [NREQ*SELECTIONDECO-1:0] reqSelDecoA;
  logic [NREQ*SELECTIONDECO-1:0] reqSelDecoB;
  logic [NREQ*SELECTIONDECO-1:0] reqSelDecoC;
  logic [NREQ*SELECTIONALU-1:0]  reqSelAlu;
  logic [NREQ-1:0]               gnt;
  logic [SELECTIONDECO-1:0]      sSelDecoA;
  logic [SELECTIONDECO-1:0]      sSelDecoB;
  logic [SELECTIONDECO-1:0]      sSelDecoC;
  logic [SELECTIONALU-1:0]       sSelAlu;
  logic [1:0]                    owner;
  logic                          busy;
  logic                          timeout;
  // Debug view: dbg_state 0=IDLE 1=GRANT 2=OWN 3=DRAIN; dbg_ptr is the round-robin pointer.
  logic [1:0]                    dbg_state;
  logic [1:0]                    dbg_ptr;

  modport master (
    output req, rel, reqSelDecoA, reqSelDecoB, reqSelDecoC, reqSelAlu,
    input  gnt, sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, owner, busy, timeout,
           dbg_state, dbg_ptr
  );

  modport slave (
    input  req, rel, reqSelDecoA, reqSelDecoB, reqSelDecoC, reqSelAlu,
    output gnt, sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu, owner, busy, timeout,
           dbg_state, dbg_ptr
  );
endinterface

// File: rtl/datapath_arbiter.sv
// Round-robin owner arbitration of the register-file/ALU datapath among NREQ sequencers.
// Optional watchdog revoke is compiled in with `define DATAPATH_ARBITER_WATCHDOG_EN.
module datapath_arbiter #(
  parameter int NREQ          = 2,
  parameter int SELECTIONDECO = 3,
  parameter int SELECTIONALU  = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk,
  input  logic              lowRst,
  datapath_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, OWN = 2'd2, DRAIN = 2'd3} state_t;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2) begin : g_bad_param
    $error("datapath_arbiter: NREQ must be 2..4 and TIMEOUT at least 2");
  end

  state_t                   state, state_n;
  logic [NREQ-1:0]          gnt_q, gnt_n;
  logic [1:0]               owner_q, owner_n;
  logic [1:0]               ptr_q, ptr_n;
  logic                     timeout_q, timeout_n;
  logic [NREQ-1:0]          elig;
  logic                     wd_expire;
  logic                     own_req, own_rel;
  logic                     found;
  logic [1:0]               winner;
  int                       idx;
  logic [SELECTIONDECO-1:0] sel_a, sel_b, sel_c;
  logic [SELECTIONALU-1:0]  sel_alu;

  always_comb begin
    own_req = 1'b0;
    own_rel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 2'(i)) begin
        own_req = bus.req[i];
        own_rel = bus.rel[i];
      end
    end
  end

  // First eligible requester at or above ptr, wrapping at NREQ rather than 4.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && j == idx && elig[j]) begin
          found  = 1'b1;
          winner = 2'(j);
        end
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    owner_n   = owner_q;
    ptr_n     = ptr_q;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = NREQ'(1) << winner;
          owner_n = winner;
        end
      end
      GRANT: state_n = OWN;
      OWN: begin
        // A release wins over a coincident watchdog expiry, so timeout stays low.
        if (own_rel || !own_req) begin
          state_n = DRAIN;
          gnt_n   = '0;
        end else if (wd_expire) begin
          state_n   = DRAIN;
          gnt_n     = '0;
          timeout_n = 1'b1;
        end
      end
      DRAIN: begin
        state_n = IDLE;
        owner_n = 2'd0;
        ptr_n   = (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (lowRst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      gnt_q     <= gnt_n;
      owner_q   <= owner_n;
      ptr_q     <= ptr_n;
      timeout_q <= timeout_n;
    end
  end

`ifdef DATAPATH_ARBITER_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0]   wd_cnt;
  logic [NREQ-1:0] blocked;

  // A revoked requester stays blocked until its req is seen low while IDLE.
  always_ff @(posedge clk) begin
    if (lowRst) begin
      wd_cnt  <= '0;
      blocked <= '0;
    end else begin
      if (state != OWN)              wd_cnt <= '0;
      else if (wd_cnt != {CW{1'b1}}) wd_cnt <= wd_cnt + CW'(1);
      if (state == IDLE) blocked <= blocked & bus.req;
      if (timeout_n)     blocked <= blocked | gnt_q;
    end
  end

  assign wd_expire = (state == OWN) && (wd_cnt == CW'(TIMEOUT - 1));
  assign elig      = bus.req & ~blocked;
`else
  assign wd_expire = 1'b0;
  assign elig      = bus.req;
`endif

  // Outside OWN the datapath sees the safe command: C all-ones writes no register.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_c   = '1;
    sel_alu = '0;
    if (state == OWN) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q == 2'(i)) begin
          sel_a   = bus.reqSelDecoA[i*SELECTIONDECO +: SELECTIONDECO];
          sel_b   = bus.reqSelDecoB[i*SELECTIONDECO +: SELECTIONDECO];
          sel_c   = bus.reqSelDecoC[i*SELECTIONDECO +: SELECTIONDECO];
          sel_alu = bus.reqSelAlu[i*SELECTIONALU +: SELECTIONALU];
        end
      end
    end
  end

  assign bus.sSelDecoA = sel_a;
  assign bus.sSelDecoB = sel_b;
  assign bus.sSelDecoC = sel_c;
  assign bus.sSelAlu   = sel_alu;
  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state != IDLE);
  assign bus.timeout   = timeout_q;
  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr_q;
endmodule

// File: doc/datapath_arbiter.md
# datapath_arbiter

Shares the register-file/ALU datapath (decoder selects A/B/C plus ALU opcode) between up to four sequencing requesters, for example the Padovan sequencer and a host/debug sequencer. Grants ownership with a round-robin request/grant/release handshake and muxes the owner's select buses onto the datapath. In every cycle without an owner it forces a safe no-write command. An optional watchdog revokes a grant that is held too long.

## Interface
- NREQ, 2: number of requesters, legal range 2..4
- SELECTIONDECO, 3: width of each decoder select
- SELECTIONALU, 3: width of the ALU select
- TIMEOUT, 64: maximum owned cycles before forced revoke; used only with the watchdog, minimum 2
- clk  in  1  sole clock, rising edge
- lowRst  in  1  reset; synchronous, active-high
- req  in  NREQ  per-requester ownership request
- rel  in  NREQ  per-requester release; sampled only for the current owner
- reqSelDecoA / reqSelDecoB / reqSelDecoC  in  NREQ*SELECTIONDECO  per-requester selects; requester i occupies slice [i*SELECTIONDECO +: SELECTIONDECO]
- reqSelAlu  in  NREQ*SELECTIONALU  per-requester ALU selects, sliced the same way
- gnt  out  NREQ  one-hot grant, registered
- sSelDecoA, sSelDecoB, sSelDecoC  out  SELECTIONDECO  datapath decoder selects
- sSelAlu  out  SELECTIONALU  datapath ALU select
- owner  out  2  index of the granted requester; 0 when none
- busy  out  1  high in every state other than IDLE
- timeout  out  1  one-cycle pulse on a watchdog revoke

## Operation
- States:
  - IDLE: arbitrate.
  - GRANT: guard cycle.
  - OWN: owner drives the datapath.
  - DRAIN: guard cycle.
- Safe command: A=0, B=0, C=all-ones (no register written), ALU=0. It is driven in IDLE, GRANT and DRAIN.
- In OWN the outputs are the combinational mux of the owner's reqSel* slices.
- IDLE:
  - With any req bit set, choose the first set bit searching from `ptr` upward, modulo NREQ. Go to GRANT with gnt[winner]=1 and owner=winner.
  - With no request, stay in IDLE.
- GRANT: go unconditionally to OWN; gnt is held.
- OWN, exit conditions:
  - rel[owner]=1 or req[owner]=0: the current cycle's command is still driven from the owner. Next state is DRAIN and gnt clears.
  - rel from a non-owner is ignored.
- DRAIN: ptr = owner+1 modulo NREQ; go to IDLE.
- Reset: ptr=0, state IDLE, gnt=0, owner=0, busy=0, timeout=0, watchdog counter=0, outputs at the safe command.
  - Reset in any state, including mid-ownership, aborts ownership immediately. There is no drain cycle.
- Arithmetic and width rules:
  - ptr and owner are 2 bits; the modulo is done against NREQ, not 4.
  - The watchdog counter is $clog2(TIMEOUT) bits, saturating, and cleared on entry to OWN.

## Timing
- The winner is decided from req at edge t. gnt is visible after edge t+1 (state GRANT). The owner's selects reach the datapath starting at edge t+2 (state OWN).
- Release takes effect as follows: rel seen at edge r, DRAIN after r+1, IDLE after r+2. A new grant appears after r+3.
- Minimum handover between two requesters is therefore 3 safe cycles. Owned cycles are unbounded unless the watchdog is compiled in.
- Simultaneous requests are resolved strictly by round-robin from ptr. There is no fixed priority.
- Release and watchdog expiry in the same cycle count as a normal release: timeout stays 0.
- Flags (sZero etc.) are not routed through this block. The owner samples them directly.

## Configuration
- `DATAPATH_ARBITER_WATCHDOG_EN` defined:
  - In OWN the counter increments every cycle.
  - When it has counted TIMEOUT owned cycles without a release, the next state is DRAIN and gnt clears. timeout pulses for the DRAIN cycle and ptr advances as normal.
  - The revoked requester must drop and re-raise req to compete again; a held req is treated as a fresh request only after it is seen low for at least one IDLE cycle.
- Undefined: no counter is instantiated, timeout is tied 0, and ownership lasts until release or req drop.

## Test plan
- Reset then req=2'b01:
  - gnt=01 after 1 cycle.
  - The requester 0 command (A=1, B=7, C=0, ALU=0) appears on the outputs 2 cycles after req.
  - Before that, outputs hold the safe command C=3'b111.
- Simultaneous req=2'b11 after reset: requester 0 is granted first.
  - After its release, requester 1 is granted after exactly 3 safe cycles.
  - On the next contention, requester 0 wins again.
- rel from the non-owner during OWN: ignored, gnt unchanged. A drop of req[owner] without rel releases like rel.
- lowRst asserted while owning: the next cycle has gnt=0, busy=0, the safe command, and ptr=0.
- With the watchdog compiled in, TIMEOUT=4 and req held with no rel: after 4 owned cycles, gnt=0 and timeout=1 for 1 cycle, followed by IDLE. The request is not regranted until req toggles.
- With the watchdog not compiled in, same stimulus for 1000 cycles: gnt is held and timeout stays 0.
